// File: rtl/serial_fa_pkg.sv
// Shared types and constants for the bit-serial adder: FSM encoding and the
// full-adder truth tables indexed by {a, b, carry_in}.
package serial_fa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SUM_TT   = 8'b1001_0110;
    localparam logic [7:0] CARRY_TT = 8'b1110_1000;

endpackage

// File: rtl/fa_lut.sv
// Single-bit full adder realised as two 8-entry truth-table lookups.
module fa_lut
    import serial_fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic [2:0] idx;

    assign idx = {a, b, c};
    assign s   = SUM_TT[idx];
    assign co  = CARRY_TT[idx];

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial adder/subtractor: one full-adder evaluation per clock, LSB first,
// with a carry flip-flop between bits and a start/busy/done handshake.
module serial_fa_adder
    import serial_fa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             bit_s;
    logic             bit_co;
    logic             accept;
    logic             last_bit;

    fa_lut u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_nxt = bit_s;
        end else begin : g_res_wide
            assign res_nxt = {bit_s, res_sh[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = start && (state == IDLE || state == DONE);
    assign last_bit = (state == RUN) && (cnt == LAST);

    // NOTE: state is a flop, so it is assigned with <= to avoid read/write races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction is a + ~b + 1: invert b on load and force the first carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= op ? ~b : b;
            carry <= op ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            carry  <= bit_co;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= res_nxt;
                cout <= bit_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_fa_adder.sv
// Directed bench for serial_fa_adder at WIDTH=8, 4 and 1, plus a standalone fa_lut.
module tb_serial_fa_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8 instance
    logic       st8, o8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [7:0] prev_s;
    logic       prev_c;

    serial_fa_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .op(o8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    // WIDTH=4 instance
    logic       st4, o4, c4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    serial_fa_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .op(o4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // WIDTH=1 instance
    logic st1, o1, c1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    serial_fa_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .op(o1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    logic fl_a, fl_b, fl_c, fl_s, fl_co;

    fa_lut u_lut (.a(fl_a), .b(fl_b), .c(fl_c), .s(fl_s), .co(fl_co));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run8(input string tag, input logic o, input logic [7:0] av,
                        input logic [7:0] bv, input logic ci,
                        input logic [7:0] es, input logic ec);
        st8 = 1'b1; o8 = o; a8 = av; b8 = bv; c8 = ci;
        @(negedge clk);
        st8 = 1'b0; o8 = ~o; a8 = ~av; b8 = ~bv; c8 = ~ci;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("%s busy c%0d", tag, c), 64'({busy8, done8}), 64'b10);
            check($sformatf("%s hold c%0d", tag, c), 64'({cout8, sum8}), 64'({prev_c, prev_s}));
            @(negedge clk);
        end
        check($sformatf("%s done", tag), 64'({busy8, done8}), 64'b01);
        check($sformatf("%s result", tag), 64'({cout8, sum8}), 64'({ec, es}));
        prev_s = es;
        prev_c = ec;
    endtask

    initial begin
        logic       ok;
        logic [4:0] r4;
        logic [3:0] es4;
        logic       ec4, es1, ec1;

        rst_n = 1'b0;
        {st8, o8, c8, a8, b8} = '0;
        {st4, o4, c4, a4, b4} = '0;
        {st1, o1, c1, a1, b1} = '0;
        {fl_a, fl_b, fl_c} = '0;
        prev_s = 8'h00;
        prev_c = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [1:0] fr;
            {fl_a, fl_b, fl_c} = 3'(i);
            #1;
            fr = 2'(fl_a) + 2'(fl_b) + 2'(fl_c);
            check($sformatf("lut %0d", i), 64'({fl_co, fl_s}), 64'(fr));
        end

        repeat (2) @(negedge clk);
        check("reset w8", 64'({busy8, done8, cout8, sum8}), 64'd0);
        check("reset w4", 64'({busy4, done4, cout4, sum4}), 64'd0);
        check("reset w1", 64'({busy1, done1, cout1, sum1}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run8("add 5a+3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        @(negedge clk);
        check("idle after done", 64'({busy8, done8}), 64'b00);
        run8("add ff+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        run8("add ff+ff+1", 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        @(negedge clk);
        run8("add 12+34+1", 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
        @(negedge clk);
        run8("sub 10-01", 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        @(negedge clk);
        run8("sub 01-02", 1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        run8("sub 05-03 cin", 1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1);
        @(negedge clk);
        run8("sub 80-80", 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("idle hold", 64'({cout8, sum8}), 64'({1'b1, 8'h00}));

        // Start held through the DONE cycle chains the next op with no bubble.
        run8("b2b first", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run8("b2b second", 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        @(negedge clk);

        // Start pulsed mid-RUN must not disturb the operation in flight.
        st8 = 1'b1; o8 = 1'b0; a8 = 8'h01; b8 = 8'h02; c8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        st8 = 1'b1; o8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; c8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (4) @(negedge clk);
        check("midstart c8", 64'({busy8, done8}), 64'b10);
        @(negedge clk);
        check("midstart done", 64'({busy8, done8}), 64'b01);
        check("midstart result", 64'({cout8, sum8}), 64'({1'b0, 8'h03}));
        @(negedge clk);
        check("midstart no rerun", 64'({busy8, done8}), 64'b00);

        // Reset during RUN abandons the operation.
        st8 = 1'b1; o8 = 1'b0; a8 = 8'h77; b8 = 8'h11; c8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset clear", 64'({busy8, done8, cout8, sum8}), 64'd0);
        ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 || busy8) ok = 1'b0;
        end
        check("midreset no done", 64'(ok), 64'd1);

        // WIDTH=4: every operand pair, both carries and both ops, back-to-back.
        for (int o = 0; o < 2; o++)
            for (int ci = 0; ci < 2; ci++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        st4 = 1'b1; o4 = o[0]; c4 = ci[0]; a4 = x[3:0]; b4 = y[3:0];
                        @(negedge clk);
                        st4 = 1'b0;
                        ok = 1'b1;
                        for (int c = 1; c <= 4; c++) begin
                            if (!busy4 || done4) ok = 1'b0;
                            @(negedge clk);
                        end
                        if (o == 0) begin
                            r4  = 5'(x) + 5'(y) + 5'(ci);
                            es4 = r4[3:0];
                            ec4 = r4[4];
                        end else begin
                            es4 = 4'(x - y);
                            ec4 = (x >= y);
                        end
                        check($sformatf("w4 op%0d c%0d %0h %0h", o, ci, x, y),
                              64'({ok, busy4, done4, ec4, es4}),
                              64'({1'b1, 1'b0, 1'b1, ec4, es4}) & 64'h1FF);
                        check($sformatf("w4 val op%0d c%0d %0h %0h", o, ci, x, y),
                              64'({cout4, sum4}), 64'({ec4, es4}));
                    end
        @(negedge clk);

        // WIDTH=1: single RUN cycle, done two cycles after start.
        for (int o = 0; o < 2; o++)
            for (int ci = 0; ci < 2; ci++)
                for (int x = 0; x < 2; x++)
                    for (int y = 0; y < 2; y++) begin
                        st1 = 1'b1; o1 = o[0]; c1 = ci[0]; a1 = x[0:0]; b1 = y[0:0];
                        @(negedge clk);
                        st1 = 1'b0;
                        ok = busy1 && !done1;
                        @(negedge clk);
                        if (o == 0) begin
                            es1 = x[0] ^ y[0] ^ ci[0];
                            ec1 = (x + y + ci) >= 2;
                        end else begin
                            es1 = x[0] ^ y[0];
                            ec1 = (x >= y);
                        end
                        check($sformatf("w1 op%0d c%0d %0d %0d", o, ci, x, y),
                              64'({ok, busy1, done1, cout1, sum1}),
                              64'({1'b1, 1'b0, 1'b1, ec1, es1}));
                    end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_fa_adder.md
Name: serial_fa_adder

Overview:
- Parametrised bit-serial adder/subtractor built around a single truth-table full adder: one sum bit per clock, LSB first.
- A carry flip-flop closes the loop between bits.
- Successor to the 8:1-mux full-adder cell: adds operand width, a subtract mode, and a start/busy/done handshake.
- Used wherever area matters more than latency, e.g. accumulators fed from slow peripherals.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = add (a+b+cin), 1 = subtract (a-b, cin ignored)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry in for add, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  result, held until the next accepted start completes
- cout  output  1  final carry; in subtract mode 1 = no borrow (a>=b unsigned)

Behaviour:
- Reset: synchronous, active when rst_n=0 at a clk edge; has priority over everything.
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry and counter all cleared.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- Start acceptance: start=1 in IDLE or DONE at an edge.
  - Load a_sh=a.
  - Load b_sh=b (add) or ~b (subtract).
  - Load carry=cin (add) or 1 (subtract).
  - Clear bit counter; go to RUN.
  - start in RUN is ignored, with no effect on the operation in flight.
- RUN, each edge:
  - Evaluate fa_lut on index {a_sh[0], b_sh[0], carry}.
  - Shift the sum bit into the result register MSB; result register shifts right.
  - Shift a_sh and b_sh right by one.
  - carry = lut carry.
  - Counter increments.
  - When counter reaches WIDTH-1, that edge processes the final bit, updates sum/cout and moves to DONE.
- Latency: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1.
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next state is RUN if start=1 (back-to-back, no bubble), else IDLE.
- Output updates:
  - sum/cout update only on the transition into DONE.
  - Intermediate partial results never appear on sum.
  - In IDLE they hold the last result.
- Arithmetic: modulo 2^WIDTH; cout is the carry out of bit WIDTH-1; no overflow flag.
- Counter width: $clog2(WIDTH+1); WIDTH=1 gives a single RUN cycle.
- No X propagation: a, b, cin and op are don't-care outside the start cycle.

Decomposition:
- Package serial_fa_pkg:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - FA truth-table constants, indexed by {a,b,c}: SUM_TT=8'b1001_0110, CARRY_TT=8'b1110_1000.
- Sub-module fa_lut: combinational.
  - Inputs: a, b, c.
  - Outputs: s=SUM_TT[{a,b,c}], co=CARRY_TT[{a,b,c}].
  - Verified standalone, exhaustively over 8 inputs.

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0, start in cycle 0 -> busy cycles 1..8, done in cycle 9, sum=0x96, cout=0.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Add a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Subtract a=0x10, b=0x01 -> sum=0x0F, cout=1. Subtract a=0x01, b=0x02 -> sum=0xFF, cout=0.
- start pulsed mid-RUN with different operands -> ignored; original result reported at cycle 9. start held in the DONE cycle -> new op begins, second done exactly 9 cycles later.
- rst_n=0 at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
- WIDTH=1 and WIDTH=4 builds: exhaustive a, b, cin, op checked against a reference model; done 2 and 5 cycles after start respectively.
